seg7_scan_driver: RTL and testbench

Time-multiplexed, parametrised driver for an N-digit common-anode/cathode seven-segment display. It latches a packed digit word, decodes each 4-bit digit to segments with optional hex and leading-zero suppression, and scans the anodes at a programmable rate with 16-level PWM brightness. Display updates are frame-synchronous, so a refresh never tears. It sits between the clock/calendar counters and the board display pins.

---
 rtl/seg7_pkg.sv | 8 +
 rtl/seg7_scan_driver_if.sv | 22 ++
 rtl/seg7_decode.sv | 12 +
 rtl/seg7_scan_driver.sv | 100 ++++++++++
 tb/tb_seg7_scan_driver.sv | 189 ++++++++++++++++++
 5 files changed

// File: rtl/seg7_pkg.sv
// seg7_pkg: seven-segment pattern constants shared by decoder and driver
package seg7_pkg;
  localparam logic [6:0] SEG_BLANK = 7'h00;
  localparam logic [6:0] SEG_TABLE [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };
endpackage

// File: rtl/seg7_scan_driver_if.sv
// seg7_scan_driver_if: digit load/brightness inputs and scanned display outputs
// master drives load/digits_in/dp_in/lz_en/brightness; slave drives seg/dp/an/pending/frame_done
interface seg7_scan_driver_if #(parameter int NUM_DIGITS = 8);
  logic                    load;
  logic [4*NUM_DIGITS-1:0] digits_in;
  logic [NUM_DIGITS-1:0]   dp_in;
  logic                    lz_en;
  logic [3:0]              brightness;
  logic [6:0]              seg;
  logic                    dp;
  logic [NUM_DIGITS-1:0]   an;
  logic                    pending;
  logic                    frame_done;
  modport master (
    output load, digits_in, dp_in, lz_en, brightness,
    input  seg, dp, an, pending, frame_done
  );
  modport slave (
    input  load, digits_in, dp_in, lz_en, brightness,
    output seg, dp, an, pending, frame_done
  );
endinterface

// File: rtl/seg7_decode.sv
// seg7_decode: 4-bit digit to active-high {g..a} segments; 10..15 blank unless HEX_EN
// ports: digit in 4, seg out 7
module seg7_decode
  import seg7_pkg::*;
#(
  parameter bit HEX_EN = 1'b0
) (
  input  logic [3:0] digit,
  output logic [6:0] seg
);
  always_comb seg = (!HEX_EN && digit > 4'd9) ? SEG_BLANK : SEG_TABLE[digit];
endmodule

// File: rtl/seg7_scan_driver.sv
// seg7_scan_driver: frame-synchronous multiplexed N-digit seven-segment driver with 16-level PWM
// ports: clk, rst (sync, active high), bus (slave): load/digits_in/dp_in/lz_en/brightness in,
// seg/dp/an registered out, pending (shadow waiting for frame end), frame_done (end-of-scan pulse)
module seg7_scan_driver
  import seg7_pkg::*;
#(
  parameter int NUM_DIGITS     = 8,
  parameter int SCAN_DIV       = 50000,
  parameter bit HEX_EN         = 1'b0,
  parameter bit SEG_ACTIVE_LOW = 1'b1,
  parameter bit AN_ACTIVE_LOW  = 1'b1
) (
  input logic clk,
  input logic rst,
  seg7_scan_driver_if.slave bus
);
  localparam int PW = $clog2(SCAN_DIV);
  localparam int IW = NUM_DIGITS > 1 ? $clog2(NUM_DIGITS) : 1;
  localparam int DW = 4 * NUM_DIGITS;
  localparam logic [6:0] SEG_OFF = {7{SEG_ACTIVE_LOW}};
  localparam logic [NUM_DIGITS-1:0] AN_OFF = {NUM_DIGITS{AN_ACTIVE_LOW}};
  logic [PW-1:0] pcnt_q, pcnt_d;
  logic [IW-1:0] idx_q, idx_d;
  logic pending_q, pending_d, frame_done_q, frame_done_d;
  logic [DW-1:0] sh_dig_q, sh_dig_d, act_dig_q, act_dig_d;
  logic [NUM_DIGITS-1:0] sh_dp_q, sh_dp_d, act_dp_q, act_dp_d;
  logic sh_lz_q, sh_lz_d, act_lz_q, act_lz_d;
  logic [6:0] seg_q, seg_d, dec_seg;
  logic dp_q, dp_d;
  logic [NUM_DIGITS-1:0] an_q, an_d, lz_blank;
  logic [3:0] cur_digit;
  logic tc, boundary, lit, zero_run;
  seg7_decode #(.HEX_EN(HEX_EN)) u_decode (.digit(cur_digit), .seg(dec_seg));
  // a digit is suppressed when it and every more-significant digit are zero; digit 0 always shows
  always_comb begin
    lz_blank = '0;
    zero_run = 1'b1;
    for (int i = NUM_DIGITS - 1; i > 0; i--) begin
      zero_run = zero_run && act_dig_q[4*i +: 4] == 4'd0;
      lz_blank[i] = act_lz_q && zero_run;
    end
  end
  always_comb begin
    tc = pcnt_q == PW'(SCAN_DIV - 1);
    boundary = tc && idx_q == IW'(NUM_DIGITS - 1);
    pcnt_d = tc ? '0 : pcnt_q + 1'b1;
    idx_d = !tc ? idx_q : boundary ? '0 : idx_q + 1'b1;
    frame_done_d = boundary;
    // a load on the boundary cycle itself stays pending for the following frame
    pending_d = bus.load || (pending_q && !boundary);
    sh_dig_d = bus.load ? bus.digits_in : sh_dig_q;
    sh_dp_d = bus.load ? bus.dp_in : sh_dp_q;
    sh_lz_d = bus.load ? bus.lz_en : sh_lz_q;
    act_dig_d = boundary && pending_q ? sh_dig_q : act_dig_q;
    act_dp_d = boundary && pending_q ? sh_dp_q : act_dp_q;
    act_lz_d = boundary && pending_q ? sh_lz_q : act_lz_q;
    // PWM phase is the slot divided into 16 equal steps
    lit = 4'(pcnt_q / PW'(SCAN_DIV / 16)) <= bus.brightness;
    cur_digit = act_dig_q[4*idx_q +: 4];
    seg_d = (lit && !lz_blank[idx_q] ? dec_seg : SEG_BLANK) ^ SEG_OFF;
    dp_d = (lit && act_dp_q[idx_q]) ^ SEG_ACTIVE_LOW;
    an_d = (lit ? NUM_DIGITS'(1) << idx_q : '0) ^ AN_OFF;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      pcnt_q <= '0;
      idx_q <= '0;
      pending_q <= 1'b0;
      frame_done_q <= 1'b0;
      sh_dig_q <= '0;
      sh_dp_q <= '0;
      sh_lz_q <= 1'b0;
      act_dig_q <= '0;
      act_dp_q <= '0;
      act_lz_q <= 1'b0;
      seg_q <= SEG_OFF;
      dp_q <= SEG_ACTIVE_LOW;
      an_q <= AN_OFF;
    end else begin
      pcnt_q <= pcnt_d;
      idx_q <= idx_d;
      pending_q <= pending_d;
      frame_done_q <= frame_done_d;
      sh_dig_q <= sh_dig_d;
      sh_dp_q <= sh_dp_d;
      sh_lz_q <= sh_lz_d;
      act_dig_q <= act_dig_d;
      act_dp_q <= act_dp_d;
      act_lz_q <= act_lz_d;
      seg_q <= seg_d;
      dp_q <= dp_d;
      an_q <= an_d;
    end
  end
  assign bus.seg = seg_q;
  assign bus.dp = dp_q;
  assign bus.an = an_q;
  assign bus.pending = pending_q;
  assign bus.frame_done = frame_done_q;
endmodule

// File: tb/tb_seg7_scan_driver.sv
// tb_seg7_scan_driver: randomized scoreboard bench for two driver instances (HEX_EN 0 and 1)
module tb_seg7_scan_driver;
  localparam int N = 4, SD = 32, NSD = N * SD;
  localparam logic [6:0] TBL [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };
  typedef struct {
    int          st;
    logic [15:0] dig;
    logic [3:0]  dp;
    logic        lz;
  } ld_t;
  logic clk = 0, rst = 1, load = 0, lz_en = 0;
  logic [15:0] digits_in = '0;
  logic [3:0] dp_in = '0, brightness = 4'd15;
  int tests = 0, fails = 0;
  ld_t iq[$];
  ld_t lq[$];
  seg7_scan_driver_if #(.NUM_DIGITS(N)) b0 ();
  seg7_scan_driver_if #(.NUM_DIGITS(N)) b1 ();
  assign b0.load = load;
  assign b0.digits_in = digits_in;
  assign b0.dp_in = dp_in;
  assign b0.lz_en = lz_en;
  assign b0.brightness = brightness;
  assign b1.load = load;
  assign b1.digits_in = digits_in;
  assign b1.dp_in = dp_in;
  assign b1.lz_en = lz_en;
  assign b1.brightness = brightness;
  seg7_scan_driver #(.NUM_DIGITS(N), .SCAN_DIV(SD), .HEX_EN(1'b0)) u0 (.clk(clk), .rst(rst), .bus(b0.slave));
  seg7_scan_driver #(.NUM_DIGITS(N), .SCAN_DIV(SD), .HEX_EN(1'b1)) u1 (.clk(clk), .rst(rst), .bus(b1.slave));
  always #5 clk = ~clk;

  task automatic chk(string name, int h, logic [31:0] act, logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s (hex_en=%0d) at %0t: got %h expected %h", name, h, $time, act, exp);
    end
  endtask

  task automatic check_dut(int h, logic [6:0] s, logic d, logic [3:0] a, logic pn, logic fd,
                           logic [6:0] es, logic ed, logic [3:0] ea, logic epn, logic efd);
    chk("seg", h, 32'(s), 32'(es));
    chk("dp", h, 32'(d), 32'(ed));
    chk("an", h, 32'(a), 32'(ea));
    chk("pending", h, 32'(pn), 32'(epn));
    chk("frame_done", h, 32'(fd), 32'(efd));
  endtask

  function automatic logic [6:0] exp_raw(ld_t d, int slot, bit hex);
    int v = int'((d.dig >> (4 * slot)) & 16'hF);
    if (d.lz && slot > 0 && (d.dig >> (4 * slot)) == 16'h0) return 7'h00;
    if (v > 9 && !hex) return 7'h00;
    return TBL[v];
  endfunction

  // monitor: each negedge the outputs reflect the state of the previous cycle (index st)
  initial begin
    bit have = 0, p_rst = 0, p_load = 0;
    logic [3:0] p_br = '0;
    int st = 0;
    forever begin
      @(negedge clk);
      if (have) begin
        if (p_rst) begin
          st = 0;
          lq.delete();
          check_dut(0, b0.seg, b0.dp, b0.an, b0.pending, b0.frame_done, 7'h7F, 1'b1, 4'hF, 1'b0, 1'b0);
          check_dut(1, b1.seg, b1.dp, b1.an, b1.pending, b1.frame_done, 7'h7F, 1'b1, 4'hF, 1'b0, 1'b0);
        end else begin
          ld_t cur;
          int lim, slot, p, nb;
          bit on, epn;
          logic [6:0] r0, r1;
          if (p_load) begin
            if (iq.size() == 0) chk("issued_load", 0, 32'd0, 32'd1);
            else begin
              cur = iq.pop_front();
              cur.st = st;
              lq.push_back(cur);
            end
          end
          // frame f shows the last load issued at least two cycles before its start
          lim = (st / NSD) * NSD - 2;
          while (lq.size() > 1 && lq[1].st <= lim) void'(lq.pop_front());
          cur = '{0, 16'h0, 4'h0, 1'b0};
          if (lq.size() > 0 && lq[0].st <= lim) cur = lq[0];
          epn = 1'b0;
          if (lq.size() > 0) begin
            nb = (lq[$].st / NSD) * NSD + NSD - 1;
            if (nb == lq[$].st) nb += NSD;
            epn = st < nb;
          end
          slot = (st / SD) % N;
          p = st % SD;
          on = (p / (SD / 16)) <= int'(p_br);
          r0 = on ? exp_raw(cur, slot, 1'b0) : 7'h00;
          r1 = on ? exp_raw(cur, slot, 1'b1) : 7'h00;
          check_dut(0, b0.seg, b0.dp, b0.an, b0.pending, b0.frame_done, ~r0, ~(on && cur.dp[slot]),
                    on ? ~(4'b0001 << slot) : 4'hF, epn, st % NSD == NSD - 1);
          check_dut(1, b1.seg, b1.dp, b1.an, b1.pending, b1.frame_done, ~r1, ~(on && cur.dp[slot]),
                    on ? ~(4'b0001 << slot) : 4'hF, epn, st % NSD == NSD - 1);
          st++;
        end
      end
      have = 1;
      p_rst = rst;
      p_load = load;
      p_br = brightness;
    end
  end

  task automatic wait_cyc(int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    rst = 1;
    wait_cyc(1);
    rst = 0;
  endtask

  task automatic do_load(logic [15:0] d, logic [3:0] p, logic z);
    iq.push_back('{0, d, p, z});
    load = 1;
    digits_in = d;
    dp_in = p;
    lz_en = z;
    wait_cyc(1);
    load = 0;
    digits_in = 16'(($urandom));
    dp_in = 4'($urandom);
    lz_en = 1'($urandom);
  endtask

  function automatic logic [15:0] rand_digits();
    logic [15:0] d = '0;
    for (int i = 0; i < 4; i++) d[4*i +: 4] = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom);
    return d;
  endfunction

  initial begin
    @(posedge clk);
    #1;
    wait_cyc(2);
    do_reset();
    do_load(16'h1234, 4'h0, 1'b0);
    wait_cyc(300);
    do_load(16'h0050, 4'h0, 1'b1);
    wait_cyc(300);
    do_load(16'h00AF, 4'b0101, 1'b0);
    wait_cyc(300);
    brightness = 4'd3;
    wait_cyc(300);
    brightness = 4'd15;
    wait_cyc(50);
    do_load(16'h5678, 4'h1, 1'b0);
    wait_cyc(9);
    do_load(16'h9012, 4'h2, 1'b1);
    wait_cyc(300);
    do_load(16'h4321, 4'h8, 1'b0);
    wait_cyc(20);
    do_reset();
    wait_cyc(200);
    do_reset();
    wait_cyc(127);
    do_load(16'hBEEF, 4'hF, 1'b0);
    wait_cyc(300);
    for (int k = 0; k < 40; k++) begin
      brightness = 4'($urandom);
      wait_cyc($urandom_range(0, 200));
      if ($urandom_range(0, 14) == 0) do_reset();
      do_load(rand_digits(), 4'($urandom), 1'($urandom));
      if ($urandom_range(0, 2) == 0) begin
        wait_cyc($urandom_range(0, 20));
        do_load(rand_digits(), 4'($urandom), 1'($urandom));
      end
    end
    wait_cyc(300);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
